// File: rtl/clock_reset_seq_ctrl_if.sv
// Control/status bundle of the reset sequencer and cycle-count timer.
// The test environment drives the master side; the sequencer is the slave.
interface clock_reset_seq_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int DLY_W  = 16,
   parameter int CNT_W  = 32
) ();

   logic                    start;
   logic                    soft_rst;
   logic [NUM_CH*DLY_W-1:0] reset_delay;
   logic [NUM_CH-1:0]       ch_reset_n;
   logic                    seq_busy;
   logic                    seq_done;
   logic                    count_load;
   logic [CNT_W-1:0]        count_value;
   logic [CNT_W-1:0]        count_remaining;
   logic                    count_reached;

   modport master (
      output start, soft_rst, reset_delay, count_load, count_value,
      input  ch_reset_n, seq_busy, seq_done, count_remaining, count_reached
   );

   modport slave (
      input  start, soft_rst, reset_delay, count_load, count_value,
      output ch_reset_n, seq_busy, seq_done, count_remaining, count_reached
   );

endinterface

// File: rtl/clock_reset_seq_ctrl.sv
// Multi-channel reset sequencer plus reloadable cycle-count timer.
// Each channel's active-low reset is released a programmable number of cycles
// after a start pulse; the timer flags a one-cycle event when a loaded count
// has fully elapsed. All outputs come straight from registers.
module clock_reset_seq_ctrl #(
   parameter int NUM_CH = 4,
   parameter int DLY_W  = 16,
   parameter int CNT_W  = 32
) (
   input logic                   clock,
   input logic                   reset,
   clock_reset_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                        state_r;
   state_t                        state_nx_s;
   logic                          capture_s;
   logic                          abort_s;
   logic [NUM_CH-1:0][DLY_W-1:0]  delay_r;
   // One bit wider than the delays so a saturated count is above every delay.
   logic [DLY_W:0]                elapsed_r;
   logic [NUM_CH-1:0]             ch_rst_n_r;
   logic [NUM_CH-1:0]             release_s;
   logic                          all_rel_s;
   logic                          busy_r;
   logic                          done_r;
   logic [CNT_W-1:0]              remain_r;
   logic                          expire_r;
   logic                          reached_r;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; soft_rst outranks start, which restarts from any state.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      abort_s    = 1'b0;
      if (bus.soft_rst) begin
         abort_s    = 1'b1;
         state_nx_s = ST_IDLE;
      end else if (bus.start) begin
         capture_s  = 1'b1;
         state_nx_s = ST_SEQ;
      end else begin
         case (state_r)
            ST_SEQ: begin
               if (all_rel_s) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_SEQ;
               end
            end
            ST_IDLE, ST_DONE: state_nx_s = state_r;
            default:          state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Channels whose delay matches the elapsed count release on this edge.
   always_comb begin
      release_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((state_r == ST_SEQ) && (elapsed_r == {1'b0, delay_r[i]})) begin
            release_s[i] = 1'b1;
         end else begin
            release_s[i] = 1'b0;
         end
      end
   end

   assign all_rel_s = &(ch_rst_n_r | release_s);

   // Sequencer datapath: captured delays, elapsed counter and reset outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         delay_r    <= '0;
         elapsed_r  <= '0;
         ch_rst_n_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else if (abort_s) begin
         ch_rst_n_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else if (capture_s) begin
         delay_r    <= bus.reset_delay;
         elapsed_r  <= '0;
         ch_rst_n_r <= '0;
         busy_r     <= 1'b1;
         done_r     <= 1'b0;
      end else if (state_r == ST_SEQ) begin
         ch_rst_n_r <= ch_rst_n_r | release_s;
         if (elapsed_r != {(DLY_W+1){1'b1}}) begin
            elapsed_r <= elapsed_r + {{DLY_W{1'b0}}, 1'b1};
         end else begin
            elapsed_r <= elapsed_r;
         end
         if (all_rel_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end
      end else begin
         ch_rst_n_r <= ch_rst_n_r;
         busy_r     <= busy_r;
         done_r     <= done_r;
      end
   end

   // Down-counter; a load always wins, which also cancels a same-cycle expiry.
   // expire_r marks the 1->0 step and is delayed once more into count_reached.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         remain_r  <= '0;
         expire_r  <= 1'b0;
         reached_r <= 1'b0;
      end else begin
         reached_r <= expire_r;
         if (bus.count_load) begin
            remain_r <= bus.count_value;
            expire_r <= 1'b0;
         end else if (remain_r != {CNT_W{1'b0}}) begin
            remain_r <= remain_r - {{(CNT_W-1){1'b0}}, 1'b1};
            expire_r <= (remain_r == {{(CNT_W-1){1'b0}}, 1'b1});
         end else begin
            expire_r <= 1'b0;
         end
      end
   end

   assign bus.ch_reset_n      = ch_rst_n_r;
   assign bus.seq_busy        = busy_r;
   assign bus.seq_done        = done_r;
   assign bus.count_remaining = remain_r;
   assign bus.count_reached   = reached_r;

endmodule

// File: tb/tb_clock_reset_seq_ctrl.sv
// Self-checking bench for clock_reset_seq_ctrl. Each task queues the expected
// outputs for the edge it is about to drive and compares them after that edge.
module tb_clock_reset_seq_ctrl;

   localparam int NUM_CH = 4;
   localparam int DLY_W  = 16;
   localparam int CNT_W  = 32;

   typedef struct packed {
      logic [3:0]  ch;
      logic        busy;
      logic        done;
      logic        reached;
      logic [31:0] rem;
   } obs_t;

   logic clock;
   logic reset;
   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   clock_reset_seq_ctrl_if #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .CNT_W(CNT_W)) bus_if ();

   clock_reset_seq_ctrl #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic obs_t sample();
      obs_t o;
      o.ch      = bus_if.ch_reset_n;
      o.busy    = bus_if.seq_busy;
      o.done    = bus_if.seq_done;
      o.reached = bus_if.count_reached;
      o.rem     = bus_if.count_remaining;
      return o;
   endfunction

   // Expected sequencer outputs j edges after the start edge (timer idle).
   function automatic obs_t seq_exp(int j, logic [63:0] dl);
      obs_t e;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         e.ch[i] = (j >= 1 + int'(dl[i*16 +: 16]));
      end
      e.done = &e.ch;
      e.busy = ~e.done;
      return e;
   endfunction

   // Timer-only expectation with the sequencer idle.
   function automatic obs_t tmr_exp(int rem, logic reached);
      obs_t e;
      e = '0;
      e.rem = rem;
      e.reached = reached;
      return e;
   endfunction

   task automatic test_reset();
      obs_t got;
      obs_t e;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) begin
            @(negedge clock);
            reset = 1'b1;
         end
         exp_q.push_back(obs_t'(0));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset c=%0d got %h exp %h", c, got, e);
         end
      end
   endtask

   task automatic test_stagger();
      obs_t got;
      obs_t e;
      logic [63:0] dl;
      dl = {16'd5, 16'd5, 16'd2, 16'd0};
      for (int j = 0; j < 9; j++) begin
         @(negedge clock);
         bus_if.start = (j == 0);
         bus_if.reset_delay = dl;
         exp_q.push_back(seq_exp(j, dl));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL stagger j=%0d got %h exp %h", j, got, e);
         end
      end
      @(negedge clock);
      bus_if.start = 1'b0;
   endtask

   task automatic test_restart();
      obs_t got;
      obs_t e;
      logic [63:0] da;
      logic [63:0] db;
      da = {16'd5, 16'd5, 16'd2, 16'd0};
      db = {16'd0, 16'd3, 16'd1, 16'd1};
      for (int j = 0; j < 12; j++) begin
         @(negedge clock);
         bus_if.start = (j == 0) || (j == 4);
         bus_if.reset_delay = (j < 4) ? da : db;
         if (j < 4) exp_q.push_back(seq_exp(j, da));
         else       exp_q.push_back(seq_exp(j - 4, db));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL restart j=%0d got %h exp %h", j, got, e);
         end
      end
      @(negedge clock);
      bus_if.start = 1'b0;
   endtask

   task automatic test_abort();
      obs_t got;
      obs_t e;
      logic [63:0] dl;
      dl = {16'd2, 16'd2, 16'd2, 16'd2};
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         bus_if.start    = (c == 0) || (c == 5);
         bus_if.soft_rst = (c == 0) || (c == 7);
         bus_if.reset_delay = dl;
         if (c == 5 || c == 6) exp_q.push_back(seq_exp(c - 5, dl));
         else                  exp_q.push_back(obs_t'(0));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL abort c=%0d got %h exp %h", c, got, e);
         end
      end
      @(negedge clock);
      bus_if.start = 1'b0;
      bus_if.soft_rst = 1'b0;
   endtask

   task automatic test_timer();
      obs_t got;
      obs_t e;
      // Plain count of 4: 4,3,2,1,0 then a pulse after the fifth following edge.
      for (int j = 0; j < 8; j++) begin
         @(negedge clock);
         bus_if.count_load  = (j == 0);
         bus_if.count_value = 32'd4;
         exp_q.push_back(tmr_exp((j <= 4) ? 4 - j : 0, (j == 5)));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL timer4 j=%0d got %h exp %h", j, got, e);
         end
      end
      // Reload with 10 on the expiry edge of a count of 4.
      for (int j = 0; j < 18; j++) begin
         @(negedge clock);
         bus_if.count_load  = (j == 0) || (j == 4);
         bus_if.count_value = (j == 0) ? 32'd4 : 32'd10;
         if (j < 4) exp_q.push_back(tmr_exp(4 - j, 1'b0));
         else       exp_q.push_back(tmr_exp((j - 4 <= 10) ? 14 - j : 0, (j == 15)));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reload j=%0d got %h exp %h", j, got, e);
         end
      end
      // Load of zero cancels a running count without a pulse.
      for (int j = 0; j < 10; j++) begin
         @(negedge clock);
         bus_if.count_load  = (j == 0) || (j == 2);
         bus_if.count_value = (j == 0) ? 32'd5 : 32'd0;
         exp_q.push_back(tmr_exp((j < 2) ? 5 - j : 0, 1'b0));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL zero j=%0d got %h exp %h", j, got, e);
         end
      end
      @(negedge clock);
      bus_if.count_load = 1'b0;
   endtask

   task automatic test_async_reset();
      obs_t got;
      obs_t e;
      logic [63:0] da;
      logic [63:0] dl;
      da = {16'd8, 16'd6, 16'd4, 16'd1};
      dl = {16'd5, 16'd5, 16'd2, 16'd0};
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         bus_if.start = (j == 0);
         bus_if.count_load = (j == 0);
         bus_if.count_value = 32'd9;
         bus_if.reset_delay = da;
         e = seq_exp(j, da);
         e.rem = 9 - j;
         exp_q.push_back(e);
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL async_pre j=%0d got %h exp %h", j, got, e);
         end
      end
      // Timer reads 7 and ch0 is released; drop reset between edges.
      bus_if.start = 1'b0;
      bus_if.count_load = 1'b0;
      reset = 1'b0;
      exp_q.push_back(obs_t'(0));
      #2;
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL async_clear got %h exp %h", got, e);
      end
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clock);
         bus_if.start = (j == 0);
         bus_if.reset_delay = dl;
         exp_q.push_back(seq_exp(j, dl));
         @(posedge clock); #1;
         got = sample(); e = exp_q.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL async_fresh j=%0d got %h exp %h", j, got, e);
         end
      end
      @(negedge clock);
      bus_if.start = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      bus_if.start       = 1'b0;
      bus_if.soft_rst    = 1'b0;
      bus_if.reset_delay = '0;
      bus_if.count_load  = 1'b0;
      bus_if.count_value = '0;
      test_reset();
      test_stagger();
      test_restart();
      test_abort();
      test_timer();
      test_async_reset();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain left %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_reset_seq_ctrl.md
# clock_reset_seq_ctrl

Parametrised multi-channel reset sequencer and cycle-count timer for the testbench clock/reset infrastructure. It drives NUM_CH independent active-low reset outputs, each released after its own programmable delay from a start command. It also provides a reloadable down-counter that flags a one-cycle event when a requested number of clock cycles has elapsed, for timeouts and drain waits. It sits between the test's clock source and the DUT reset pins, and is synthesisable for emulation.

## Interface
- NUM_CH, 4, number of reset channels (1..16)
- DLY_W, 16, width of each per-channel release delay
- CNT_W, 32, width of the cycle-count timer
- clock  input  1  single clock; all logic on posedge
- reset  input  1  asynchronous, active-low block reset
- start  input  1  one-cycle pulse: capture delays, assert all channel resets, begin sequence
- soft_rst  input  1  one-cycle pulse: re-assert all channel resets, return to IDLE
- reset_delay  input  NUM_CH*DLY_W  per-channel delay, channel i at bits [i*DLY_W +: DLY_W]
- ch_reset_n  output  NUM_CH  per-channel active-low reset
- seq_busy  output  1  sequence in progress
- seq_done  output  1  all channels released
- count_load  input  1  one-cycle pulse: load count_value into timer
- count_value  input  CNT_W  cycles to count
- count_remaining  output  CNT_W  cycles left, 0 when idle
- count_reached  output  1  one-cycle pulse when timer expires

## Operation
- States: IDLE, SEQ, DONE.
- While reset is low, asynchronously: ch_reset_n = all 0, seq_busy = 0, seq_done = 0, count_remaining = 0, count_reached = 0, state = IDLE. Captured delays and the elapsed counter are also cleared.
- After reset deasserts, outputs hold these values until start. Channel resets stay asserted.
- IDLE -> SEQ on start:
  - Capture reset_delay into internal registers.
  - Clear the elapsed counter. It is DLY_W+1 bits and saturates at all-ones, so it never wraps.
  - ch_reset_n = 0, seq_busy = 1.
- In SEQ, elapsed increments each cycle. Channel i deasserts (ch_reset_n[i] = 1) on the edge where elapsed == delay[i].
- Once high, a channel stays high until start, soft_rst or reset.
- Channels with equal delays release on the same edge.
- SEQ -> DONE on the edge where the last channel releases: seq_busy = 0, seq_done = 1.
- start in SEQ or DONE restarts the sequence: recapture delays, re-assert all channels, clear elapsed, seq_done = 0.
- soft_rst in any state: ch_reset_n = 0, seq_busy = 0, seq_done = 0, go to IDLE.
- start and soft_rst in the same cycle: soft_rst wins.
- Timer, independent of the FSM:
  - count_load with N > 0: count_remaining = N.
  - While count_remaining is nonzero it decrements by 1 per cycle.
  - count_reached pulses high for exactly one cycle, on the cycle after the 1 -> 0 transition.
- count_load with N = 0 clears the timer; no pulse.
- count_load while the timer is running reloads it. A load on the same cycle as the 1 -> 0 expiry suppresses that pulse; the load wins.

## Timing
- start sampled at edge k: ch_reset_n = 0 after edge k. Channel i goes high after edge k+1+delay[i].
  - delay 0: high one cycle after start.
  - delay 3: high four cycles after start.
- seq_done rises on the same edge as the last channel release.
- soft_rst sampled at edge k: all outputs in reset state after edge k.
- count_load of N at edge k: count_remaining = N after edge k, reaches 0 after edge k+N. count_reached is high for the cycle after edge k+N+1.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Power-up: reset low for 5 cycles, then high, no start -> ch_reset_n = 4'b0000, seq_busy = 0, seq_done = 0, count_remaining = 0 throughout.
- Staggered release: delays {0, 2, 5, 5}, start at edge 10:
  - ch0 high after edge 11, ch1 after edge 13, ch2 and ch3 after edge 16.
  - seq_done = 1 after edge 16, seq_busy low on the same edge.
- Restart and abort:
  - start again at edge 14 of the staggered case -> all channels re-asserted after edge 14, sequence re-times from edge 14.
  - soft_rst together with a start -> IDLE, all outputs 0.
- Timer: count_load with N = 4 at edge 20 -> count_remaining reads 4, 3, 2, 1, 0; count_reached high only in the cycle after edge 25.
  - Reload with N = 10 at edge 24 -> no pulse from the first load.
  - N = 0 -> no pulse.
- Async reset mid-sequence: reset low between edges during SEQ with the timer at 7 -> all outputs 0 immediately without a clock edge; a subsequent start behaves as fresh.
